instr_deserialiser: RTL and testbench
=====================================

# instr_deserialiser

Serial-to-parallel front end for the instruction staticisor. It receives a store word one bit per strobe, least-significant bit first, while the machine is in the scan phase. It extracts the line-number and function-number fields and presents them as one parallel staticisor input word, qualified by a single-cycle ready pulse. It sits directly upstream of the staticisor: the staticisor latches the output word while w_HA is low and replays it during the action beat.

## Interface
Parameters:
- WORD_WIDTH, 32: bits per store word.
- LINE_BITS, 5: line field width; occupies word bits [LINE_BITS-1:0].
- FUNC_LSB, 13: bit index of the function field LSB.
- FUNC_BITS, 5: function field width; occupies bits [FUNC_LSB+FUNC_BITS-1:FUNC_LSB].
- STAT_WIDTH, LINE_BITS+FUNC_BITS: output width. Derived; not overridden.

Ports:
- w_CLK, input, 1: single clock.
- w_RST_n, input, 1: reset, synchronous, active-low.
- w_HA, input, 1: action-phase flag. The block is active only while w_HA=0.
- w_SOW, input, 1: start-of-word pulse, one cycle wide.
- w_BIT_valid, input, 1: bit strobe. One serial bit per asserted cycle.
- w_BIT, input, 1: serial data, sampled only when w_BIT_valid=1.
- b_STAT, output, STAT_WIDTH: {function field, line field}, function in the MSBs. Feeds the staticisor's b_STAT_in.
- w_ready, output, 1: one-cycle pulse when b_STAT holds a new complete word. Feeds the staticisor's ready input.
- w_ERR, output, 1: one-cycle pulse on an aborted or short word.

## Operation
- FSM states:
  - IDLE: waiting for a word.
  - SHIFT: receiving bits.
  - DONE: output update cycle.
- IDLE -> SHIFT:
  - Taken on w_SOW=1 while w_HA=0.
  - The bit counter clears to 0.
  - If w_BIT_valid=1 in the same cycle, that bit is word bit 0 and the counter becomes 1.
- SHIFT, on each strobe:
  - Bit index n = counter.
  - If n < LINE_BITS, the bit goes to shadow line[n].
  - If FUNC_LSB ≤ n < FUNC_LSB+FUNC_BITS, the bit goes to shadow func[n-FUNC_LSB].
  - All other bits are discarded.
  - The counter increments.
- SHIFT -> DONE: taken on the strobe with n = WORD_WIDTH-1.
- DONE:
  - b_STAT ← {func shadow, line shadow}.
  - w_ready=1.
  - Next state is IDLE, unconditionally.
- b_STAT holds its value until the next DONE. It is never cleared by an abort.
- Counter width is clog2(WORD_WIDTH). The counter never wraps: the terminal strobe always leaves SHIFT.
- Shadow field registers are cleared on every IDLE -> SHIFT transition, so a restart cannot leak bits from the previous word.
- Boundary cases:
  - w_SOW=1 while in SHIFT: restart from bit 0, with the same same-cycle strobe rule as IDLE. w_ERR pulses.
  - w_HA rises while in SHIFT: go to IDLE, no w_ready, w_ERR pulses.
  - w_SOW=1 while w_HA=1: ignored.
  - w_SOW=1 during DONE: ignored. Upstream guarantees at least one idle cycle between words.
  - w_BIT_valid=1 while in IDLE without w_SOW: ignored.
  - Reset asserted mid-word: the word is discarded and the block returns to IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - State = IDLE.
  - Counter = 0.
  - Shadow registers = 0.
  - b_STAT = 0.
  - w_ready = 0.
  - w_ERR = 0.
- All outputs are registered.
- Latency: w_ready and the new b_STAT appear together, one cycle after the cycle carrying the terminal strobe.
- w_ERR is asserted in the cycle after the offending w_SOW or w_HA edge is sampled.
- Strobes may be back-to-back (one per cycle) or arbitrarily spaced. Throughput is limited only by the strobe rate plus one DONE cycle per word.
- The staticisor samples b_STAT on the w_ready pulse while w_HA=0. Downstream needs no further handshake.

## Configuration
- Macro: DESER_WORD_CHECK_EN.
- Defined: w_ERR behaves as specified above.
- Undefined:
  - w_ERR is tied to 0.
  - Restarts and aborts happen silently, with identical state behaviour.

## Structure
- Package instr_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the field-position constants LINE_BITS, FUNC_LSB and FUNC_BITS;
  - STAT_WIDTH.
- The staticisor and the downstream line and function decoders share this package.
- One sub-module, bit_counter:
  - clear and increment inputs;
  - terminal-count output at WORD_WIDTH-1.

## Test plan
- Nominal word: word 0x00006013 sent LSB first at one strobe per cycle → b_STAT=0x073 (func=3, line=19), w_ready high for exactly one cycle, 1 cycle after bit 31.
- Sparse strobes and hold: the same word with strobes every 3 cycles → identical b_STAT. A following all-zero word → b_STAT=0x000. b_STAT stays 0x073 between the two words.
- Restart: w_SOW reasserted after 10 bits, then full word 0xFFFFFFFF → w_ERR pulse, then b_STAT=0x3FF, one w_ready.
- Phase abort: w_HA raised at bit 20 → no w_ready, w_ERR pulse, b_STAT unchanged. w_SOW with w_HA=1 is ignored.
- Reset mid-word: w_RST_n=0 for 1 cycle at bit 15, then a new word 0x00002001 → b_STAT=0x021 and no stale bits. With DESER_WORD_CHECK_EN undefined, the restart scenario shows w_ERR constantly 0.

Source files
------------

// File: rtl/instr_deserialiser_pkg.sv
// Shared instruction-field definitions for the deserialiser, staticisor and line/function decoders.
package instr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } deser_state_t;

  localparam int LINE_BITS  = 5;
  localparam int FUNC_LSB   = 13;
  localparam int FUNC_BITS  = 5;
  localparam int STAT_WIDTH = LINE_BITS + FUNC_BITS;

endpackage

// File: rtl/instr_deserialiser_if.sv
// Serial store-word input plus parallel staticisor output bundle; slave = deserialiser side.
interface instr_deserialiser_if;

  logic                            w_HA;
  logic                            w_SOW;
  logic                            w_BIT_valid;
  logic                            w_BIT;
  logic [instr_pkg::STAT_WIDTH-1:0] b_STAT;
  logic                            w_ready;
  logic                            w_ERR;

  modport master (
    output w_HA, w_SOW, w_BIT_valid, w_BIT,
    input  b_STAT, w_ready, w_ERR
  );

  modport slave (
    input  w_HA, w_SOW, w_BIT_valid, w_BIT,
    output b_STAT, w_ready, w_ERR
  );

endinterface

// File: rtl/instr_deserialiser_bit_counter.sv
// Serial bit index counter; clear takes priority and may count the same-cycle strobe as bit 0.
module bit_counter #(
  parameter int WORD_WIDTH = 32,
  parameter int CW         = $clog2(WORD_WIDTH)
) (
  input  logic          w_CLK,
  input  logic          w_RST_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge w_CLK) begin
    if (!w_RST_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(WORD_WIDTH - 1));

endmodule

// File: rtl/instr_deserialiser.sv
// LSB-first store word -> {func, line} staticisor word; b_STAT/w_ready one cycle after terminal strobe,
// no backpressure. w_ERR on restart/abort only when DESER_WORD_CHECK_EN is defined.
module instr_deserialiser
  import instr_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input logic                 w_CLK,
  input logic                 w_RST_n,
  instr_deserialiser_if.slave bus
);

  localparam int CW = $clog2(WORD_WIDTH);

  deser_state_t           state;
  logic [LINE_BITS-1:0]   line_sh, line_nx;
  logic [FUNC_BITS-1:0]   func_sh, func_nx;
  logic [STAT_WIDTH-1:0]  stat_q;
  logic                   ready_q;
  logic [CW-1:0]          cnt, idx;
  logic                   tc, restart, take, term;

  bit_counter #(.WORD_WIDTH(WORD_WIDTH), .CW(CW)) u_bit_counter (
    .w_CLK   (w_CLK),
    .w_RST_n (w_RST_n),
    .clr     (restart),
    .inc     (take),
    .cnt     (cnt),
    .tc      (tc)
  );

  // A restart clears the shadows and treats any same-cycle strobe as bit 0.
  always_comb begin
    restart = bus.w_SOW & ~bus.w_HA & (state != DONE);
    take    = bus.w_BIT_valid & ~bus.w_HA & (restart | (state == SHIFT));
    term    = take & ~restart & tc;
    idx     = restart ? '0 : cnt;
    line_nx = restart ? '0 : line_sh;
    func_nx = restart ? '0 : func_sh;
    for (int i = 0; i < LINE_BITS; i++) begin
      if (take && (idx == CW'(i))) line_nx[i] = bus.w_BIT;
    end
    for (int i = 0; i < FUNC_BITS; i++) begin
      if (take && (idx == CW'(FUNC_LSB + i))) func_nx[i] = bus.w_BIT;
    end
  end

  always_ff @(posedge w_CLK) begin
    if (!w_RST_n) begin
      state   <= IDLE;
      line_sh <= '0;
      func_sh <= '0;
      stat_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      line_sh <= line_nx;
      func_sh <= func_nx;
      case (state)
        IDLE: begin
          if (restart) state <= SHIFT;
        end
        SHIFT: begin
          if (bus.w_HA) begin
            state <= IDLE;
          end else if (term) begin
            state   <= DONE;
            stat_q  <= {func_nx, line_nx};
            ready_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.b_STAT  = stat_q;
  assign bus.w_ready = ready_q;

`ifdef DESER_WORD_CHECK_EN
  logic err_q;

  always_ff @(posedge w_CLK) begin
    if (!w_RST_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == SHIFT) & (bus.w_HA | bus.w_SOW);
    end
  end

  assign bus.w_ERR = err_q;
`else
  assign bus.w_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_instr_deserialiser.sv
// Directed bench for instr_deserialiser: nominal, sparse, hold, restart, abort and reset-mid-word words.
module tb_instr_deserialiser;
  import instr_pkg::*;

`ifdef DESER_WORD_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic w_CLK;
  logic w_RST_n;
  int   n_checks;
  int   n_errors;
  int   ready_cnt;
  int   err_cnt;
  int   r0;
  int   e0;

  instr_deserialiser_if ifc ();

  instr_deserialiser #(.WORD_WIDTH(32)) dut (
    .w_CLK   (w_CLK),
    .w_RST_n (w_RST_n),
    .bus     (ifc)
  );

  initial w_CLK = 1'b0;
  always #5 w_CLK = ~w_CLK;

  always @(negedge w_CLK) begin
    if (w_RST_n && ifc.w_ready === 1'b1) ready_cnt++;
    if (w_RST_n && ifc.w_ERR === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic step(input logic sow, input logic vld, input logic b, input logic ha);
    ifc.w_SOW       = sow;
    ifc.w_BIT_valid = vld;
    ifc.w_BIT       = b;
    ifc.w_HA        = ha;
    @(posedge w_CLK);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(i == 0, 1'b1, word[i], 1'b0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    ready_cnt = 0;
    err_cnt   = 0;
    w_RST_n   = 1'b0;
    ifc.w_HA = 1'b0; ifc.w_SOW = 1'b0; ifc.w_BIT_valid = 1'b0; ifc.w_BIT = 1'b0;
    @(posedge w_CLK); #1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_stat",  32'(ifc.b_STAT), 32'h000);
    check("rst_ready", 32'(ifc.w_ready), 32'd0);
    check("rst_err",   32'(ifc.w_ERR), 32'd0);
    w_RST_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Nominal back-to-back word 0x00006013 -> func=3, line=19.
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(32'h0000_6013, 31, 0);
    check("nom_no_early_ready", 32'(ifc.w_ready), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("nom_ready_lat", 32'(ifc.w_ready), 32'd1);
    check("nom_stat", 32'(ifc.b_STAT), 32'h073);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("nom_ready_drop", 32'(ifc.w_ready), 32'd0);
    check("nom_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    check("nom_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Sparse strobes (every 3 cycles), same word.
    r0 = ready_cnt;
    send_bits(32'h0000_6013, 32, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("sparse_stat", 32'(ifc.b_STAT), 32'h073);
    check("sparse_ready_cnt", 32'(ready_cnt - r0), 32'd1);

    // All-zero word: previous value held until its terminal strobe.
    send_bits(32'h0, 31, 0);
    check("hold_stat", 32'(ifc.b_STAT), 32'h073);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("zero_stat", 32'(ifc.b_STAT), 32'h000);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Field boundaries: bits 5..12 and 18..31 set as noise; fields 10101 each.
    send_bits(32'hFFFE_BFF5, 32, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("field_edge_stat", 32'(ifc.b_STAT), 32'h2B5);

    // Restart after 10 bits, then all-ones word.
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(32'h0000_0000, 10, 0);
    send_bits(32'hFFFF_FFFF, 32, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_stat", 32'(ifc.b_STAT), 32'h3FF);
    check("restart_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    check("restart_err_cnt", 32'(err_cnt - e0), 32'(ERR_EXP));

    // Phase abort at bit 20, SOW while w_HA=1, then strobes in IDLE without SOW.
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(32'h0000_6013, 20, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_stat", 32'(ifc.b_STAT), 32'h3FF);
    check("abort_ready_cnt", 32'(ready_cnt - r0), 32'd0);
    check("abort_err_cnt", 32'(err_cnt - e0), 32'(ERR_EXP));

    // Reset for one cycle at bit 15 of an all-ones word, then 0x00002001.
    send_bits(32'hFFFF_FFFF, 15, 0);
    w_RST_n = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("midrst_stat", 32'(ifc.b_STAT), 32'h000);
    check("midrst_ready", 32'(ifc.w_ready), 32'd0);
    w_RST_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    r0 = ready_cnt;
    send_bits(32'h0000_2001, 32, 0);
    check("post_rst_ready", 32'(ifc.w_ready), 32'd1);
    check("post_rst_stat", 32'(ifc.b_STAT), 32'h021);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_ready_cnt", 32'(ready_cnt - r0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
